// File: rtl/ascon_io_bridge_if.sv
// Bundle of the host job/result handshake and the bit-serial Ascon core link.
// master = host/core side, slave = the bridge.
interface ascon_io_bridge_if #(
  parameter int K = 128,
  parameter int L = 32,
  parameter int Y = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_key;
  logic [127:0] in_nonce;
  logic [L-1:0] in_ad;
  logic [Y-1:0] in_data;
  logic         in_decrypt;

  logic         core_rstxSO;
  logic         keyxSO;
  logic         noncexSO;
  logic         adxSO;
  logic         dataxSO;
  logic         startxSO;
  logic         decryptxSO;
  logic         output_dataxSI;
  logic         tagxSI;
  logic         ascon_readyxSI;

  logic         out_valid;
  logic         out_ready;
  logic [Y-1:0] out_data;
  logic [127:0] out_tag;
  logic         out_err;

  modport master (
    output in_valid, in_key, in_nonce, in_ad, in_data, in_decrypt,
    input  in_ready,
    input  core_rstxSO, keyxSO, noncexSO, adxSO, dataxSO, startxSO, decryptxSO,
    output output_dataxSI, tagxSI, ascon_readyxSI,
    input  out_valid, out_data, out_tag, out_err,
    output out_ready
  );

  modport slave (
    input  in_valid, in_key, in_nonce, in_ad, in_data, in_decrypt,
    output in_ready,
    output core_rstxSO, keyxSO, noncexSO, adxSO, dataxSO, startxSO, decryptxSO,
    input  output_dataxSI, tagxSI, ascon_readyxSI,
    output out_valid, out_data, out_tag, out_err,
    input  out_ready
  );
endinterface

// File: rtl/ascon_io_bridge.sv
// Bridges a parallel encrypt/decrypt job to a bit-serial Ascon core: resets the core,
// streams key/nonce/ad/data MSB first, starts it, and collects tag/data LSB first.
module ascon_io_bridge #(
  parameter int K       = 128,
  parameter int L       = 32,
  parameter int Y       = 32,
  parameter int TIMEOUT = 4096
) (
  input logic              clk,
  input logic              rst,
  ascon_io_bridge_if.slave bus
);
  localparam int N0 = (K > 128) ? K : 128;
  localparam int N1 = (N0 > L) ? N0 : L;
  localparam int N  = (N1 > Y) ? N1 : Y;
  localparam int M  = (Y > 128) ? Y : 128;
  localparam int NW = $clog2(N + 1);
  localparam int JW = $clog2(M + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CRST, SHIFT, GAP, START, WAIT, COLLECT, DONE
  } state_t;

  state_t state, state_nxt;

  logic [NW-1:0] cnt;
  logic [JW-1:0] cap_j;
  logic [WW-1:0] wdog;
  logic          rdy_d;

  logic [K-1:0]  key_sh;
  logic [127:0]  nonce_sh;
  logic [L-1:0]  ad_sh;
  logic [Y-1:0]  data_sh;
  logic          dec_q;

  logic [Y-1:0]  res_data;
  logic [127:0]  res_tag;
  logic          res_err;

  logic accept, shift_last, cap_en, cap_last, timeout_hit;

  assign accept      = (state == IDLE) && bus.in_valid;
  assign shift_last  = (state == SHIFT) && (cnt == NW'(N - 1));
  assign cap_en      = (state == COLLECT) && rdy_d;
  assign cap_last    = cap_en && (cap_j == JW'(M - 1));
  assign timeout_hit = (state == WAIT) && !bus.ascon_readyxSI && (wdog == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CRST;
      CRST:    state_nxt = SHIFT;
      SHIFT:   if (shift_last) state_nxt = GAP;
      GAP:     state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT: begin
        if (bus.ascon_readyxSI) state_nxt = COLLECT;
        else if (timeout_hit)   state_nxt = DONE;
      end
      COLLECT: if (cap_last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift counter, capture index and watchdog never exceed their terminal value within a job.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      cap_j   <= '0;
      wdog    <= '0;
      rdy_d   <= 1'b0;
      res_err <= 1'b0;
    end else begin
      rdy_d <= bus.ascon_readyxSI;
      if (state == CRST)       cnt <= '0;
      else if (state == SHIFT) cnt <= cnt + NW'(1);
      if (state == START)      wdog <= '0;
      else if (state == WAIT)  wdog <= wdog + WW'(1);
      if (state == START)      cap_j <= '0;
      else if (cap_en)         cap_j <= cap_j + JW'(1);
      if (timeout_hit)                          res_err <= 1'b1;
      else if ((state == DONE) && bus.out_ready) res_err <= 1'b0;
    end
  end

  // The latched job words double as shift registers; zeros fill in behind the MSB,
  // so a stream shorter than N reads 0 once it is exhausted.
  always_ff @(posedge clk) begin
    if (accept) begin
      key_sh   <= bus.in_key;
      nonce_sh <= bus.in_nonce;
      ad_sh    <= bus.in_ad;
      data_sh  <= bus.in_data;
      dec_q    <= bus.in_decrypt;
    end else if (state == SHIFT) begin
      key_sh   <= key_sh << 1;
      nonce_sh <= nonce_sh << 1;
      ad_sh    <= ad_sh << 1;
      data_sh  <= data_sh << 1;
    end
  end

  // Results shift in from the top so that bit j lands at position j after the last capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= '0;
      res_tag  <= '0;
    end else if (accept) begin
      res_data <= '0;
      res_tag  <= '0;
    end else if (cap_en) begin
      if (cap_j < JW'(128)) res_tag  <= {bus.tagxSI, res_tag[127:1]};
      if (cap_j < JW'(Y))   res_data <= {bus.output_dataxSI, res_data[Y-1:1]};
    end
  end

  always_comb begin
    bus.in_ready    = 1'b0;
    bus.core_rstxSO = rst;
    bus.keyxSO      = 1'b0;
    bus.noncexSO    = 1'b0;
    bus.adxSO       = 1'b0;
    bus.dataxSO     = 1'b0;
    bus.startxSO    = 1'b0;
    bus.decryptxSO  = (state != IDLE) && dec_q;
    bus.out_valid   = 1'b0;
    bus.out_data    = res_data;
    bus.out_tag     = res_tag;
    bus.out_err     = res_err;
    case (state)
      IDLE:  bus.in_ready    = 1'b1;
      CRST:  bus.core_rstxSO = 1'b1;
      SHIFT: begin
        bus.keyxSO   = key_sh[K-1];
        bus.noncexSO = nonce_sh[127];
        bus.adxSO    = ad_sh[L-1];
        bus.dataxSO  = data_sh[Y-1];
      end
      START: bus.startxSO  = 1'b1;
      DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: doc/ascon_io_bridge.md
ASCON_IO_BRIDGE -- requirements
Module: ascon_io_bridge

Interface
REQ-001 Parameters (name, default, meaning): K, 128, key width; L, 32, associated-data width; Y, 32, plaintext/ciphertext width; TIMEOUT, 4096, max cycles waiting for core ready.
REQ-002 Reset is rst, synchronous, active-high; clock is clk; all state updates on rising clk.
REQ-003 Ports (name direction width meaning):
- clk in 1 clock
- rst in 1 sync active-high reset
- in_valid in 1 job request
- in_ready out 1 bridge idle, accepts job
- in_key in K key
- in_nonce in 128 nonce
- in_ad in L associated data
- in_data in Y plaintext/ciphertext
- in_decrypt in 1 1=decrypt
- core_rstxSO out 1 reset to Ascon core
- keyxSO, noncexSO, adxSO, dataxSO out 1 each, serial bits to core
- startxSO out 1 core start pulse
- decryptxSO out 1 core decrypt select
- output_dataxSI, tagxSI in 1 each, serial result bits from core
- ascon_readyxSI in 1 core ready
- out_valid out 1 result held
- out_ready in 1 result consumed
- out_data out Y result data
- out_tag out 128 tag
- out_err out 1 timeout flag

Function
REQ-004 Let N = max(K,128,L,Y); states IDLE, CRST, SHIFT, GAP, START, WAIT, COLLECT, DONE.
REQ-005 in_ready = 1 only in IDLE; job accepted when in_valid & in_ready; accept latches all in_* fields, goes IDLE->CRST.
REQ-006 CRST lasts 1 cycle with core_rstxSO=1; core_rstxSO is also 1 whenever rst=1; 0 otherwise.
REQ-007 SHIFT lasts exactly N cycles, counter c=0..N-1; each stream presents its latched word MSB first: keyxSO = key[K-1-c] for c<K, else 0; same rule for nonce (128), ad (L), data (Y).
REQ-008 GAP lasts 1 cycle, all serial outputs 0 (core load counter reaches N+1, core ready).
REQ-009 START lasts 1 cycle with startxSO=1; startxSO is 0 in every other state.
REQ-010 decryptxSO equals latched in_decrypt from CRST through DONE; 0 in IDLE.
REQ-011 WAIT: watchdog counts cycles; ascon_readyxSI=1 -> COLLECT; watchdog reaching TIMEOUT -> DONE with out_err=1, out_data/out_tag = 0.
REQ-012 COLLECT: register rdy_d = ascon_readyxSI delayed 1 cycle; on each cycle with rdy_d=1, capture bit index j (0-based, LSB first): tag[j]=tagxSI for j<128; data[j]=output_dataxSI for j<Y; j increments only on capture.
REQ-013 Ready dropping mid-COLLECT pauses capture without loss; COLLECT ends after capture j=max(Y,128)-1 -> DONE.
REQ-014 DONE: out_valid=1, out_data/out_tag/out_err stable; out_valid & out_ready -> IDLE same edge, out_valid 0 next cycle; out_err cleared on leaving DONE.
REQ-015 in_valid outside IDLE is ignored; latched fields do not change until next accept.
REQ-016 Counters sized for N, max(Y,128) and TIMEOUT without wrap; no counter wraps within a job.

Reset
REQ-017 rst=1 at any state, including mid-SHIFT or mid-COLLECT, forces IDLE next edge; outputs after reset: in_ready=1, core_rstxSO=1 during rst, all serial outputs 0, startxSO=0, decryptxSO=0, out_valid=0, out_err=0, out_data=0, out_tag=0.
REQ-018 Job in progress at reset is discarded; no out_valid produced for it.

Verification
REQ-019 Encrypt, key=000102..0F, nonce=101112..1F, ad=0xA5A5A5A5, data=0xDEADBEEF -> core_rstxSO 1 cycle, 128 SHIFT cycles, keyxSO first bit 0 (bit 127), adxSO bits 0 after 32 cycles, startxSO pulse exactly 130 cycles after CRST, decryptxSO=0.
REQ-020 Core model holds ready high and drives tag bit j = j[0], data bit j = 1 -> out_tag = 0xAAAA..AA, out_data=0xFFFFFFFF, out_valid after exactly 129 cycles from first ready.
REQ-021 Ready toggled 1/0 every cycle during COLLECT -> capture pauses, identical out_data/out_tag as REQ-020.
REQ-022 Ready never asserted, TIMEOUT=16 -> DONE after 16 WAIT cycles, out_err=1, out_data=0, out_tag=0.
REQ-023 rst asserted at SHIFT c=40 -> next cycle IDLE, in_ready=1, serial outputs 0; new job runs normally.
REQ-024 out_ready held 0 for 10 cycles in DONE -> out_valid and results stable 10 cycles; in_valid ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
